tile_match_engine: RTL and testbench

- In-game core of the tile-matching game. It sits directly downstream of the game-mode FSM: it consumes that FSM's ingameOn and produces the gameOver it waits on.
- It runs a 16-tile concentration board. The player picks two tiles using switches and a key. Matching pairs stay matched; a mismatched pair is shown for a fixed delay and then hidden again.
- It counts moves and found pairs, and asserts gameOver when every pair has been found. Its masks and counters drive the VGA and HEX display logic.

---
 rtl/tile_game_pkg.sv | 30 +++
 rtl/tile_layout_rom.sv | 20 ++
 rtl/tile_match_engine.sv | 182 ++++++++++++++++++
 tb/tb_tile_match_engine.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_game_pkg.sv
// Shared definitions for the tile-matching game core.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
//
// Contents:
//   state_t   - in-game FSM state encoding
//   NUM_PAIRS - number of tile pairs on the 16-tile board
//   pair_id() - board layout: tile index -> pair id
package tile_game_pkg;

   localparam int NUM_PAIRS = 8;

   typedef enum logic [2:0] {
      S_IDLE          = 3'd0,
      S_WAIT_FIRST    = 3'd1,
      S_WAIT_SECOND   = 3'd2,
      S_COMPARE       = 3'd3,
      S_SHOW_MISMATCH = 3'd4,
      S_DONE          = 3'd5
   } state_t;

   // ((5*i+3) mod 16) >> 1. Because 5 is odd, 5*i+3 is a permutation of
   // 0..15, so dropping the LSB gives every id 0..7 exactly twice.
   function automatic logic [2:0] pair_id(input logic [3:0] idx);
      logic [7:0] t;
      t = ({4'b0000, idx} * 8'd5) + 8'd3;
      return t[3:1];
   endfunction

endpackage

// File: rtl/tile_layout_rom.sv
// Board layout lookup: two independent tile index -> pair id read ports.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; always ready.
//
// Ports:
//   idx_a_i, idx_b_i : tile indices to look up
//   id_a_o,  id_b_o  : corresponding 3-bit pair ids
module tile_layout_rom
   import tile_game_pkg::*;
(
   input  logic [3:0] idx_a_i,
   input  logic [3:0] idx_b_i,
   output logic [2:0] id_a_o,
   output logic [2:0] id_b_o
);

   assign id_a_o = pair_id(idx_a_i);
   assign id_b_o = pair_id(idx_b_i);

endmodule

// File: rtl/tile_match_engine.sv
// In-game core of the concentration game: two-tile picks, match/mismatch
// handling, move and pair counting, game-over detection.
// Latency: state updates on the edge that sees the event; a mismatched pair
//   stays visible for 1 + MISMATCH_DELAY cycles; picks while busy are dropped.
//
// Ports:
//   CLOCK_50    : system clock
//   userquit    : asynchronous active-high reset
//   ingameOn    : high while the mode FSM is in its in-game mode
//   tile_sel    : tile index sampled on a select_key rising edge
//   select_key  : synchronised pick key (active high)
//   revealed    : face-up, unmatched tiles
//   matched     : tiles already matched
//   moves       : completed two-tile moves, saturating at 255
//   pairs_found : pairs found so far (0..8)
//   busy        : high in COMPARE / SHOW_MISMATCH
//   gameOver    : high in DONE
module tile_match_engine
   import tile_game_pkg::*;
#(
   parameter int NUM_TILES      = 16,
   parameter int MISMATCH_DELAY = 25000000
) (
   input  logic                 CLOCK_50,
   input  logic                 userquit,
   input  logic                 ingameOn,
   input  logic [3:0]           tile_sel,
   input  logic                 select_key,
   output logic [NUM_TILES-1:0] revealed,
   output logic [NUM_TILES-1:0] matched,
   output logic [7:0]           moves,
   output logic [3:0]           pairs_found,
   output logic                 busy,
   output logic                 gameOver
);

   // Timer counts MISMATCH_DELAY-1 down to 0.
   localparam int TW = (MISMATCH_DELAY > 1) ? $clog2(MISMATCH_DELAY) : 1;

   state_t               state_q, state_d;
   logic [NUM_TILES-1:0] revealed_q, revealed_d;
   logic [NUM_TILES-1:0] matched_q, matched_d;
   logic [7:0]           moves_q, moves_d;
   logic [3:0]           pairs_q, pairs_d;
   logic [TW-1:0]        timer_q, timer_d;
   logic [3:0]           first_q, first_d;
   logic [3:0]           second_q, second_d;
   logic                 key_q;

   logic [2:0]           id_first, id_second;
   logic                 pick_evt, pick_ok;
   logic [NUM_TILES-1:0] sel_bit, pair_bits;

   tile_layout_rom u_layout (
      .idx_a_i (first_q),
      .idx_b_i (second_q),
      .id_a_o  (id_first),
      .id_b_o  (id_second)
   );

   // Rising edge of the key: holding it down yields a single pick.
   assign pick_evt = select_key & ~key_q;
   // A tile that is face-up or already matched cannot be picked again.
   assign pick_ok  = pick_evt & ~matched_q[tile_sel] & ~revealed_q[tile_sel];

   always_comb begin
      sel_bit            = '0;
      sel_bit[tile_sel]  = 1'b1;
      pair_bits          = '0;
      pair_bits[first_q]  = 1'b1;
      pair_bits[second_q] = 1'b1;
   end

   always_ff @(posedge CLOCK_50 or posedge userquit) begin
      if (userquit) begin
         state_q    <= S_IDLE;
         revealed_q <= '0;
         matched_q  <= '0;
         moves_q    <= '0;
         pairs_q    <= '0;
         timer_q    <= '0;
         first_q    <= '0;
         second_q   <= '0;
         key_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         revealed_q <= revealed_d;
         matched_q  <= matched_d;
         moves_q    <= moves_d;
         pairs_q    <= pairs_d;
         timer_q    <= timer_d;
         first_q    <= first_d;
         second_q   <= second_d;
         key_q      <= select_key;
      end
   end

   always_comb begin
      state_d    = state_q;
      revealed_d = revealed_q;
      matched_d  = matched_q;
      moves_d    = moves_q;
      pairs_d    = pairs_q;
      timer_d    = timer_q;
      first_d    = first_q;
      second_d   = second_q;

      // Leaving the in-game mode wins over anything else this cycle; the
      // score (matched, moves, pairs) stays for the end screen.
      if (state_q != S_IDLE && !ingameOn) begin
         state_d    = S_IDLE;
         revealed_d = '0;
         timer_d    = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (ingameOn) begin
                  revealed_d = '0;
                  matched_d  = '0;
                  moves_d    = '0;
                  pairs_d    = '0;
                  state_d    = S_WAIT_FIRST;
               end
            end

            S_WAIT_FIRST: begin
               if (pick_ok) begin
                  revealed_d = revealed_q | sel_bit;
                  first_d    = tile_sel;
                  state_d    = S_WAIT_SECOND;
               end
            end

            S_WAIT_SECOND: begin
               if (pick_ok) begin
                  revealed_d = revealed_q | sel_bit;
                  second_d   = tile_sel;
                  moves_d    = (moves_q == 8'hFF) ? moves_q : moves_q + 8'd1;
                  state_d    = S_COMPARE;
               end
            end

            S_COMPARE: begin
               if (id_first == id_second) begin
                  matched_d  = matched_q | pair_bits;
                  revealed_d = revealed_q & ~pair_bits;
                  pairs_d    = pairs_q + 4'd1;
                  state_d    = (pairs_q == 4'(NUM_PAIRS - 1)) ? S_DONE : S_WAIT_FIRST;
               end else begin
                  timer_d = TW'(MISMATCH_DELAY - 1);
                  state_d = S_SHOW_MISMATCH;
               end
            end

            S_SHOW_MISMATCH: begin
               if (timer_q == '0) begin
                  revealed_d = revealed_q & ~pair_bits;
                  state_d    = S_WAIT_FIRST;
               end else begin
                  timer_d = timer_q - TW'(1);
               end
            end

            S_DONE: begin
               // Held here until ingameOn drops (handled above).
            end

            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   assign revealed    = revealed_q;
   assign matched     = matched_q;
   assign moves       = moves_q;
   assign pairs_found = pairs_q;
   assign busy        = (state_q == S_COMPARE) || (state_q == S_SHOW_MISMATCH);
   assign gameOver    = (state_q == S_DONE);

endmodule

// File: tb/tb_tile_match_engine.sv
module tb_tile_match_engine;

   localparam int D = 4;

   logic        clk;
   logic        userquit;
   logic        ingameOn;
   logic [3:0]  tile_sel;
   logic        select_key;
   logic [15:0] revealed;
   logic [15:0] matched;
   logic [7:0]  moves;
   logic [3:0]  pairs_found;
   logic        busy;
   logic        gameOver;

   int n_tests = 0;
   int n_fail  = 0;

   tile_match_engine #(.NUM_TILES(16), .MISMATCH_DELAY(D)) dut (
      .CLOCK_50    (clk),
      .userquit    (userquit),
      .ingameOn    (ingameOn),
      .tile_sel    (tile_sel),
      .select_key  (select_key),
      .revealed    (revealed),
      .matched     (matched),
      .moves       (moves),
      .pairs_found (pairs_found),
      .busy        (busy),
      .gameOver    (gameOver)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural reference model ----------------
   // The game is described as: a list of face-up picks, a count of cycles
   // the board is still busy after a second pick (1 for a match, 1+D for a
   // mismatch), and the score. Nothing here mirrors the RTL state machine.
   bit        m_active;
   bit        m_over;
   int        m_picks[$];
   int        m_busy;
   bit [15:0] m_mat;
   int        m_moves;
   int        m_pairs;
   bit        m_prev_key;

   function automatic int pid(int i);
      return ((5 * i + 3) % 16) / 2;
   endfunction

   function automatic int partner(int i);
      for (int j = 0; j < 16; j++)
         if (j != i && pid(j) == pid(i)) return j;
      return i;
   endfunction

   function automatic bit [15:0] m_rev();
      bit [15:0] r = '0;
      foreach (m_picks[k]) r[m_picks[k]] = 1'b1;
      return r;
   endfunction

   task automatic model_reset();
      m_active = 0; m_over = 0; m_picks.delete(); m_busy = 0;
      m_mat = '0; m_moves = 0; m_pairs = 0; m_prev_key = 0;
   endtask

   task automatic model_step(input bit ing, input bit key, input int tile);
      bit evt;
      bit face_up;
      evt = key && !m_prev_key;
      m_prev_key = key;
      face_up = 0;
      foreach (m_picks[k]) if (m_picks[k] == tile) face_up = 1;
      if (!m_active) begin
         if (ing) begin
            m_active = 1; m_mat = '0; m_moves = 0; m_pairs = 0;
         end
      end else if (!ing) begin
         m_active = 0; m_over = 0; m_picks.delete(); m_busy = 0;
      end else if (m_over) begin
         // finished game: nothing happens until the mode drops
      end else if (m_busy > 0) begin
         m_busy--;
         if (m_busy == 0) begin
            if (pid(m_picks[0]) == pid(m_picks[1])) begin
               m_mat[m_picks[0]] = 1'b1;
               m_mat[m_picks[1]] = 1'b1;
               m_pairs++;
               if (m_pairs == 8) m_over = 1;
            end
            m_picks.delete();
         end
      end else if (evt && !m_mat[tile] && !face_up) begin
         m_picks.push_back(tile);
         if (m_picks.size() == 2) begin
            if (m_moves < 255) m_moves++;
            m_busy = (pid(m_picks[0]) == pid(m_picks[1])) ? 1 : 1 + D;
         end
      end
   endtask

   task automatic check_model();
      logic [45:0] act, exp;
      act = {revealed, matched, moves, pairs_found, busy, gameOver};
      exp = {m_rev(), m_mat, 8'(m_moves), 4'(m_pairs), (m_busy > 0), m_over};
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL model t=%0t act rev=%h mat=%h mv=%0d pf=%0d busy=%b go=%b exp rev=%h mat=%h mv=%0d pf=%0d busy=%b go=%b",
                  $time, revealed, matched, moves, pairs_found, busy, gameOver,
                  m_rev(), m_mat, m_moves, m_pairs, (m_busy > 0), m_over);
      end
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Inputs are driven after a falling edge; the model steps on the rising
   // edge with the same inputs; outputs are compared at the next falling edge.
   task automatic tick();
      @(posedge clk);
      model_step(ingameOn, select_key, int'(tile_sel));
      @(negedge clk);
      check_model();
   endtask

   task automatic do_reset();
      select_key = 1'b0;
      userquit   = 1'b1;
      #1;
      model_reset();
      check("reset_outputs", {18'b0, revealed, matched, moves, pairs_found, busy, gameOver}, 64'd0);
      @(posedge clk);
      @(negedge clk);
      userquit = 1'b0;
   endtask

   task automatic pick(input int t);
      tile_sel = 4'(t); select_key = 1'b1; tick();
      select_key = 1'b0; tick();
   endtask

   task automatic wait_not_busy();
      int n = 0;
      while (busy && n < 20) begin tick(); n++; end
      check("busy_timeout", {63'b0, busy}, 64'd0);
   endtask

   // ---------------- table-driven vectors ----------------
   typedef struct {
      logic        ing;
      logic        key;
      logic [3:0]  tile;
      logic [15:0] rev;
      logic [15:0] mat;
      logic [7:0]  mv;
      logic [3:0]  pf;
      logic        bsy;
      logic        go;
   } vec_t;

   vec_t vt[22];

   function automatic vec_t mkv(logic ing, logic key, logic [3:0] tile, logic [15:0] rev,
                                logic [15:0] mat, logic [7:0] mv, logic [3:0] pf,
                                logic bsy, logic go);
      vec_t v;
      v.ing = ing; v.key = key; v.tile = tile; v.rev = rev; v.mat = mat;
      v.mv = mv; v.pf = pf; v.bsy = bsy; v.go = go;
      return v;
   endfunction

   initial begin
      int t;
      userquit = 1'b1; ingameOn = 1'b0; tile_sel = 4'd0; select_key = 1'b0;
      model_reset();
      @(negedge clk);
      do_reset();

      //           ing key tile rev      mat      mv pf bsy go
      vt[0]  = mkv(1, 0, 0,  16'h0000, 16'h0000, 0, 0, 0, 0); // enter game
      vt[1]  = mkv(1, 1, 0,  16'h0001, 16'h0000, 0, 0, 0, 0); // first pick 0
      vt[2]  = mkv(1, 0, 3,  16'h0001, 16'h0000, 0, 0, 0, 0);
      vt[3]  = mkv(1, 1, 3,  16'h0009, 16'h0000, 1, 0, 1, 0); // second pick 3 -> COMPARE
      vt[4]  = mkv(1, 0, 3,  16'h0000, 16'h0009, 1, 1, 0, 0); // matched
      vt[5]  = mkv(1, 1, 0,  16'h0000, 16'h0009, 1, 1, 0, 0); // matched tile ignored
      vt[6]  = mkv(1, 0, 0,  16'h0000, 16'h0009, 1, 1, 0, 0);
      vt[7]  = mkv(1, 1, 1,  16'h0002, 16'h0009, 1, 1, 0, 0); // pick 1
      vt[8]  = mkv(1, 0, 1,  16'h0002, 16'h0009, 1, 1, 0, 0);
      vt[9]  = mkv(1, 1, 1,  16'h0002, 16'h0009, 1, 1, 0, 0); // revealed tile ignored
      vt[10] = mkv(1, 0, 2,  16'h0002, 16'h0009, 1, 1, 0, 0);
      vt[11] = mkv(1, 1, 2,  16'h0006, 16'h0009, 2, 1, 1, 0); // pick 2: ids 4 vs 6
      vt[12] = mkv(1, 0, 2,  16'h0006, 16'h0009, 2, 1, 1, 0);
      vt[13] = mkv(1, 1, 5,  16'h0006, 16'h0009, 2, 1, 1, 0); // pick while busy dropped
      vt[14] = mkv(1, 0, 5,  16'h0006, 16'h0009, 2, 1, 1, 0);
      vt[15] = mkv(1, 0, 5,  16'h0006, 16'h0009, 2, 1, 1, 0); // 5th busy cycle
      vt[16] = mkv(1, 0, 5,  16'h0000, 16'h0009, 2, 1, 0, 0); // hidden again
      vt[17] = mkv(1, 1, 5,  16'h0020, 16'h0009, 2, 1, 0, 0); // pick 5
      vt[18] = mkv(1, 1, 2,  16'h0020, 16'h0009, 2, 1, 0, 0); // held key: no event
      vt[19] = mkv(0, 0, 2,  16'h0000, 16'h0009, 2, 1, 0, 0); // mode drops: keep score
      vt[20] = mkv(0, 0, 2,  16'h0000, 16'h0009, 2, 1, 0, 0);
      vt[21] = mkv(1, 0, 2,  16'h0000, 16'h0000, 0, 0, 0, 0); // new game clears

      for (int i = 0; i < 22; i++) begin
         ingameOn = vt[i].ing; select_key = vt[i].key; tile_sel = vt[i].tile;
         tick();
         check($sformatf("vec%0d", i),
               {18'b0, revealed, matched, moves, pairs_found, busy, gameOver},
               {18'b0, vt[i].rev, vt[i].mat, vt[i].mv, vt[i].pf, vt[i].bsy, vt[i].go});
      end

      // ---- reset while a mismatch is on display ----
      pick(4);
      tile_sel = 4'd6; select_key = 1'b1; tick();
      select_key = 1'b0; tick();
      tick();
      check("in_show_busy", {63'b0, busy}, 64'd1);
      do_reset();
      ingameOn = 1'b1; tick();
      pick(4);
      check("after_reset_pick", {48'b0, revealed}, 64'h0010);

      // ---- full game with held key and invalid picks ----
      ingameOn = 1'b0; tick();
      ingameOn = 1'b1; tick();
      tile_sel = 4'd0; select_key = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      select_key = 1'b0; tick();
      check("held_key_rev", {48'b0, revealed}, 64'h0001);
      pick(0);
      check("repick_revealed", {48'b0, revealed}, 64'h0001);
      pick(3);
      wait_not_busy();
      check("first_pair_mv", {56'b0, moves}, 64'd1);
      pick(0);
      check("pick_matched", {48'b0, revealed}, 64'h0000);
      begin
         int pa[7] = '{6, 10, 4, 1, 8, 2, 12};
         for (int i = 0; i < 7; i++) begin
            pick(pa[i]);
            pick(partner(pa[i]));
            wait_not_busy();
         end
      end
      check("game_over", {63'b0, gameOver}, 64'd1);
      for (int i = 0; i < 3; i++) tick();
      check("game_over_held", {63'b0, gameOver}, 64'd1);
      ingameOn = 1'b0; tick();
      check("drop_go", {63'b0, gameOver}, 64'd0);
      check("drop_mat", {48'b0, matched}, 64'hFFFF);
      check("drop_mv", {56'b0, moves}, 64'd8);

      // ---- moves saturation ----
      ingameOn = 1'b1; tick();
      for (int i = 0; i < 300; i++) begin
         pick(0);
         pick(1);
         wait_not_busy();
      end
      check("moves_sat", {56'b0, moves}, 64'd255);

      // ---- randomized play ----
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 999) == 0) do_reset();
         ingameOn   = ($urandom_range(0, 63) != 0);
         select_key = 1'($urandom_range(0, 1));
         if (m_picks.size() == 1 && $urandom_range(0, 1) == 1) t = partner(m_picks[0]);
         else t = int'($urandom_range(0, 15));
         tile_sel = 4'(t);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
